// File: rtl/vx_tcu_drl_max_exp_pkg.sv
// Shared constants, helper functions and the stage-2 result record for the
// TCU DRL max-exponent stage.
package vx_tcu_drl_max_exp_pkg;

    localparam int N     = 2;
    localparam int TCK   = 2 * N;
    localparam int NT    = TCK + 1;   // product terms plus the C term
    localparam int NP    = N + 1;     // pair maxima plus the C term
    localparam int W     = 25;
    localparam int EXP_W = 10;

    function automatic int max_shift_f(input int win);
        return 2 * win;
    endfunction

    function automatic int shift_w_f(input int max_shift);
        return $clog2(max_shift + 1);
    endfunction

    localparam int MAX_SHIFT = max_shift_f(W);
    localparam int SHIFT_W   = shift_w_f(MAX_SHIFT);

    localparam logic [EXP_W-1:0] LP_MOST_NEG = {1'b1, {(EXP_W-1){1'b0}}};

    typedef struct packed {
        logic [EXP_W-1:0]                max_exp;
        logic [NT-1:0][SHIFT_W-1:0]      shift_amt;
        logic [TCK-1:0][SHIFT_W-1:0]     sub_shift;
        logic [TCK-1:0]                  low_larger;
        logic                            all_zero;
    } tcu_exp_align_t;

endpackage

// File: rtl/vx_tcu_drl_exp_max_tree.sv
// Combinational masked signed-max reduction. Masked entries never win; when
// every entry is masked the result is the most-negative value and o_all_zero
// is set, so a genuine most-negative exponent is still distinguishable.
module vx_tcu_drl_exp_max_tree #(
    parameter int COUNT = 2,
    parameter int WIDTH = 10
) (
    input  logic [COUNT-1:0][WIDTH-1:0] i_exp,
    input  logic [COUNT-1:0]            i_zero,
    output logic [WIDTH-1:0]            o_max,
    output logic                        o_all_zero
);

    // Linear scan keeping the running signed maximum of unmasked entries.
    always_comb begin
        o_max      = {1'b1, {(WIDTH-1){1'b0}}};
        o_all_zero = 1'b1;
        for (int i = 0; i < COUNT; i++) begin
            if (!i_zero[i] && (o_all_zero || ($signed(i_exp[i]) > $signed(o_max)))) begin
                o_max      = i_exp[i];
                o_all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vx_tcu_drl_max_exp.sv
// TCU DRL max-exponent stage: finds the signed max over non-zero term
// exponents and produces saturated alignment shifts. Two-stage pipeline with
// valid/ready backpressure. Optional counters: TCU_DRL_MAX_EXP_STATS_EN.
module vx_tcu_drl_max_exp
    import vx_tcu_drl_max_exp_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [NT*EXP_W-1:0]       raw_exp_y,
    input  logic [NT-1:0]             term_zero,
    input  logic [TCK-1:0]            exp_low_larger,
    input  logic [TCK*7-1:0]          raw_exp_diff,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [EXP_W-1:0]          max_exp,
    output logic [NT*SHIFT_W-1:0]     shift_amt,
    output logic [TCK*SHIFT_W-1:0]    sub_shift,
    output logic [TCK-1:0]            low_larger_out,
    output logic                      all_zero
`ifdef TCU_DRL_MAX_EXP_STATS_EN
    ,
    output logic [31:0]               sat_count,
    output logic [31:0]               zero_count
`endif
);

    localparam logic signed [EXP_W:0] LP_MS_D = (EXP_W+1)'(MAX_SHIFT);
    localparam logic [7:0]            LP_MS_8 = 8'(MAX_SHIFT);
    localparam logic [SHIFT_W-1:0]    LP_MS   = SHIFT_W'(MAX_SHIFT);

    logic [2:1]                  r_vld_pipe;
    logic                        w_s2_adv;
    logic [NT-1:0][EXP_W-1:0]    w_exp;
    logic [TCK-1:0][6:0]         w_diff_in;
    logic [NP-1:0][EXP_W-1:0]    w_pmax;
    logic [NP-1:0]               w_pzero;

    logic [NP-1:0][EXP_W-1:0]    r_s1_pmax;
    logic [NP-1:0]               r_s1_pzero;
    logic [NT-1:0][EXP_W-1:0]    r_s1_exp;
    logic [NT-1:0]               r_s1_zero;
    logic [TCK-1:0]              r_s1_ll;
    logic [TCK-1:0][6:0]         r_s1_diff;

    logic [EXP_W-1:0]            w_tmax;
    logic                        w_tall0;
    logic signed [EXP_W:0]       w_diff;
    logic [7:0]                  w_abs;
    logic                        w_any_sat;
    tcu_exp_align_t              w_nxt;
    tcu_exp_align_t              r_out;

    assign w_exp     = raw_exp_y;
    assign w_diff_in = raw_exp_diff;
    assign w_s2_adv  = ~r_vld_pipe[2] | ready_out;
    assign ready_in  = ~r_vld_pipe[1] | w_s2_adv;

    // Stage-1 pair maxima; the C term rides alone in the last slot.
    for (genvar p = 0; p < N; p++) begin : g_pair
        vx_tcu_drl_exp_max_tree #(.COUNT(2), .WIDTH(EXP_W)) u_pair (
            .i_exp      (w_exp[2*p+1:2*p]),
            .i_zero     (term_zero[2*p+1:2*p]),
            .o_max      (w_pmax[p]),
            .o_all_zero (w_pzero[p])
        );
    end
    assign w_pmax[N]  = term_zero[TCK] ? LP_MOST_NEG : w_exp[TCK];
    assign w_pzero[N] = term_zero[TCK];

    // Stage-2 final reduction over pair maxima.
    vx_tcu_drl_exp_max_tree #(.COUNT(NP), .WIDTH(EXP_W)) u_final (
        .i_exp      (r_s1_pmax),
        .i_zero     (r_s1_pzero),
        .o_max      (w_tmax),
        .o_all_zero (w_tall0)
    );

    // Valid pipeline: each stage advances when empty or its successor moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
        end else begin
            if (ready_in) r_vld_pipe[1] <= valid_in;
            if (w_s2_adv) r_vld_pipe[2] <= r_vld_pipe[1];
        end
    end

    // Stage-1 data capture on an accepted input beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_pmax  <= '0;
            r_s1_pzero <= '1;
            r_s1_exp   <= '0;
            r_s1_zero  <= '1;
            r_s1_ll    <= '0;
            r_s1_diff  <= '0;
        end else if (valid_in && ready_in) begin
            r_s1_pmax  <= w_pmax;
            r_s1_pzero <= w_pzero;
            r_s1_exp   <= w_exp;
            r_s1_zero  <= term_zero;
            r_s1_ll    <= exp_low_larger;
            r_s1_diff  <= w_diff_in;
        end
    end

    // Stage-2 shift computation; differences use one extra bit so a max near
    // the top of the range minus a very negative exponent cannot wrap.
    always_comb begin
        w_nxt            = '0;
        w_diff           = '0;
        w_abs            = '0;
        w_any_sat        = 1'b0;
        w_nxt.all_zero   = w_tall0;
        w_nxt.max_exp    = w_tall0 ? '0 : w_tmax;
        w_nxt.low_larger = r_s1_ll;
        for (int i = 0; i < NT; i++) begin
            w_diff = {w_nxt.max_exp[EXP_W-1], w_nxt.max_exp} - {r_s1_exp[i][EXP_W-1], r_s1_exp[i]};
            if (r_s1_zero[i]) begin
                w_nxt.shift_amt[i] = LP_MS;
            end else if (w_diff > LP_MS_D) begin
                w_nxt.shift_amt[i] = LP_MS;
                w_any_sat          = 1'b1;
            end else begin
                w_nxt.shift_amt[i] = w_diff[SHIFT_W-1:0];
            end
        end
        // 8-bit magnitude so that -64 becomes +64 rather than wrapping.
        for (int i = 0; i < TCK; i++) begin
            w_abs = r_s1_diff[i][6] ? (8'd0 - {1'b1, r_s1_diff[i]}) : {1'b0, r_s1_diff[i]};
            w_nxt.sub_shift[i] = (w_abs > LP_MS_8) ? LP_MS : w_abs[SHIFT_W-1:0];
        end
    end

    // Stage-2 output register, held while the downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out          <= '0;
            r_out.all_zero <= 1'b1;
        end else if (r_vld_pipe[1] && w_s2_adv) begin
            r_out <= w_nxt;
        end
    end

    assign valid_out      = r_vld_pipe[2];
    assign max_exp        = r_out.max_exp;
    assign shift_amt      = r_out.shift_amt;
    assign sub_shift      = r_out.sub_shift;
    assign low_larger_out = r_out.low_larger;
    assign all_zero       = r_out.all_zero;

`ifdef TCU_DRL_MAX_EXP_STATS_EN
    logic        r_s2_sat;
    logic [31:0] r_sat_count;
    logic [31:0] r_zero_count;

    // Saturation flag travels with the stage-2 result; counters bump per
    // consumed output beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_sat     <= 1'b0;
            r_sat_count  <= '0;
            r_zero_count <= '0;
        end else begin
            if (r_vld_pipe[1] && w_s2_adv) r_s2_sat <= w_any_sat;
            if (valid_out && ready_out) begin
                if (r_s2_sat)       r_sat_count  <= r_sat_count + 32'd1;
                if (r_out.all_zero) r_zero_count <= r_zero_count + 32'd1;
            end
        end
    end

    assign sat_count  = r_sat_count;
    assign zero_count = r_zero_count;
`endif

endmodule

// File: tb/tb_vx_tcu_drl_max_exp.sv
// Randomized + directed bench for vx_tcu_drl_max_exp with an in-bench
// reference model and scoreboard queue.
module tb_vx_tcu_drl_max_exp;

    typedef struct packed {
        logic [49:0] ex;
        logic [4:0]  z;
        logic [27:0] df;
        logic [3:0]  ll;
    } beat_t;

    typedef struct packed {
        logic [9:0]  mx;
        logic [29:0] sh;
        logic [23:0] sb;
        logic [3:0]  ll;
        logic        az;
        logic        sat;
    } res_t;

    logic        clk = 1'b0;
    logic        reset, valid_in, ready_in, valid_out, ready_out, all_zero;
    logic [49:0] raw_exp_y;
    logic [4:0]  term_zero;
    logic [3:0]  exp_low_larger, low_larger_out;
    logic [27:0] raw_exp_diff;
    logic [9:0]  max_exp;
    logic [29:0] shift_amt;
    logic [23:0] sub_shift;
`ifdef TCU_DRL_MAX_EXP_STATS_EN
    logic [31:0] sat_count, zero_count;
    int          sat_m = 0, zero_m = 0;
`endif

    int    checks = 0, errors = 0;
    beat_t q[$];
    bit    prev_stall = 0;
    logic [68:0] prev_o;
    res_t  mr, pr;
    int    occ;
    bit    rnd_done;

    vx_tcu_drl_max_exp dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .raw_exp_y(raw_exp_y), .term_zero(term_zero), .exp_low_larger(exp_low_larger),
        .raw_exp_diff(raw_exp_diff), .valid_out(valid_out), .ready_out(ready_out),
        .max_exp(max_exp), .shift_amt(shift_amt), .sub_shift(sub_shift),
        .low_larger_out(low_larger_out), .all_zero(all_zero)
`ifdef TCU_DRL_MAX_EXP_STATS_EN
        , .sat_count(sat_count), .zero_count(zero_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: max over non-zero exponents, shifts = max - exp clamped at 50.
    function automatic res_t model(input beat_t b);
        res_t r;
        int   e[5];
        int   m, s, d;
        bit   any;
        r = '0; m = 0; any = 0;
        for (int i = 0; i < 5; i++) e[i] = $signed(b.ex[i*10 +: 10]);
        for (int i = 0; i < 5; i++)
            if (!b.z[i] && (!any || e[i] > m)) begin m = e[i]; any = 1; end
        r.az = !any;
        r.mx = 10'(m);
        for (int i = 0; i < 5; i++) begin
            s = b.z[i] ? 50 : m - e[i];
            if (s > 50) begin
                s = 50;
                if (!b.z[i]) r.sat = 1'b1;
            end
            r.sh[i*6 +: 6] = 6'(s);
        end
        for (int j = 0; j < 4; j++) begin
            d = $signed(b.df[j*7 +: 7]);
            if (d < 0) d = -d;
            if (d > 50) d = 50;
            r.sb[j*6 +: 6] = 6'(d);
        end
        r.ll = b.ll;
        return r;
    endfunction

    function automatic beat_t mk(input int t0, input int t1, input int t2, input int t3,
                                 input int c, input logic [4:0] z,
                                 input logic [27:0] df, input logic [3:0] ll);
        beat_t b;
        b.ex = {10'(c), 10'(t3), 10'(t2), 10'(t1), 10'(t0)};
        b.z  = z;
        b.df = df;
        b.ll = ll;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        int base;
        base = int'($urandom_range(0, 600)) - 300;
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 7) == 0) b.ex[i*10 +: 10] = 10'($urandom);
            else b.ex[i*10 +: 10] = 10'(base + int'($urandom_range(0, 70)) - 35);
            b.z[i] = ($urandom_range(0, 3) == 0);
        end
        if ($urandom_range(0, 15) == 0) b.z = '1;
        b.df = 28'($urandom);
        b.ll = 4'($urandom);
        return b;
    endfunction

    task automatic apply(input beat_t b);
        raw_exp_y      = b.ex;
        term_zero      = b.z;
        raw_exp_diff   = b.df;
        exp_low_larger = b.ll;
    endtask

    // Present a beat until accepted; called at posedge+#1, returns at posedge+#1.
    task automatic send(input beat_t b);
        bit a;
        int n;
        apply(b);
        valid_in = 1'b1;
        a = 0; n = 0;
        while (!a && n < 200) begin
            @(negedge clk);
            a = ready_in;
            @(posedge clk);
            #1;
            n++;
        end
        if (!a) begin
            errors++;
            $display("FAIL send_timeout got=0 expected=1");
        end
        valid_in = 1'b0;
    endtask

    // Single beat into an empty pipe with ready_out=1; checks 2-cycle latency
    // and the result fields against literals.
    task automatic directed(input string nm, input beat_t b, input logic [9:0] mx,
                            input logic [29:0] sh, input logic [23:0] sb, input logic az);
        apply(b);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1_vo"}, valid_out, 1'b0);
        @(negedge clk);
        chk({nm, "_lat2_vo"}, valid_out, 1'b1);
        chk({nm, "_max"}, max_exp, mx);
        chk({nm, "_shift"}, shift_amt, sh);
        chk({nm, "_sub"}, sub_shift, sb);
        chk({nm, "_ll"}, low_larger_out, b.ll);
        chk({nm, "_az"}, all_zero, az);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / protocol monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            prev_stall = 0;
            chk("rst_state", {valid_out, max_exp, shift_amt, sub_shift, low_larger_out, all_zero},
                {1'b0, 10'd0, 30'd0, 24'd0, 4'd0, 1'b1});
`ifdef TCU_DRL_MAX_EXP_STATS_EN
            sat_m = 0; zero_m = 0;
`endif
        end else begin
            occ = q.size();
            chk("ready_in", ready_in, (occ < 2) || ready_out);
`ifdef TCU_DRL_MAX_EXP_STATS_EN
            chk("sat_count", sat_count, 32'(sat_m));
            chk("zero_count", zero_count, 32'(zero_m));
`endif
            if (valid_out) begin
                if (q.size() == 0) begin
                    chk("spurious_vo", valid_out, 1'b0);
                end else begin
                    mr = model(q[0]);
                    chk("out", {max_exp, shift_amt, sub_shift, low_larger_out, all_zero},
                        {mr.mx, mr.sh, mr.sb, mr.ll, mr.az});
                    if (prev_stall)
                        chk("stall_hold", {max_exp, shift_amt, sub_shift, low_larger_out, all_zero}, prev_o);
                    if (ready_out) begin
                        pr = q.pop_front();
`ifdef TCU_DRL_MAX_EXP_STATS_EN
                        if (mr.sat) sat_m++;
                        if (mr.az)  zero_m++;
`endif
                    end
                end
            end else if (prev_stall) begin
                chk("stall_vo", valid_out, 1'b1);
            end
            prev_stall = valid_out && !ready_out;
            prev_o     = {max_exp, shift_amt, sub_shift, low_larger_out, all_zero};
            if (valid_in && ready_in) q.push_back({raw_exp_y, term_zero, raw_exp_diff, exp_low_larger});
        end
    end

    beat_t b1, b2, b3, b4, bt;
    res_t  r;

    initial begin
        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
        raw_exp_y = '0; term_zero = '0; raw_exp_diff = '0; exp_low_larger = '0;

        b1 = mk(100, 110, 105, 90, 120, 5'b00000, 28'd0, 4'b0000);
        b2 = mk(200, 7, 8, -30, 9, 5'b10110, 28'd0, 4'b0000);
        b3 = mk(1, 2, 3, 4, 5, 5'b11111, 28'd0, 4'b0000);
        b4 = mk(10, 10, 10, 10, 10, 5'b00000, {7'h7B, 7'd7, 7'h40, 7'd0}, 4'b1010);

        // Pin the reference model with hand-computed values.
        r = model(b1);
        chk("pin1", {r.mx, r.sh, r.az}, {10'd120, 6'd0, 6'd30, 6'd15, 6'd10, 6'd20, 1'b0});
        r = model(b2);
        chk("pin2", {r.mx, r.sh, r.sat}, {10'd200, 6'd50, 6'd50, 6'd50, 6'd50, 6'd0, 1'b1});
        r = model(b3);
        chk("pin3", {r.mx, r.sh, r.az}, {10'd0, 6'd50, 6'd50, 6'd50, 6'd50, 6'd50, 1'b1});
        r = model(b4);
        chk("pin4", {r.sb, r.sh}, {6'd5, 6'd7, 6'd50, 6'd0, 30'd0});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        directed("t1", b1, 10'd120, {6'd0, 6'd30, 6'd15, 6'd10, 6'd20}, 24'd0, 1'b0);
        directed("t2", b2, 10'd200, {6'd50, 6'd50, 6'd50, 6'd50, 6'd0}, 24'd0, 1'b0);
        directed("t3", b3, 10'd0, {5{6'd50}}, 24'd0, 1'b1);
        directed("t4", b4, 10'd10, 30'd0, {6'd5, 6'd7, 6'd50, 6'd0}, 1'b0);

        // Stall: two beats fill the pipe, then ready_in must drop.
        ready_out = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(rnd_beat());
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("t5_ready_low", ready_in, 1'b0);
                chk("t5_vo_held", valid_out, 1'b1);
                repeat (3) @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Reset with two beats in flight.
        ready_out = 1'b0;
        send(b1);
        send(b2);
        reset = 1'b1;
        #1;
        chk("t6_vo_rst", valid_out, 1'b0);
        chk("t6_az_rst", {all_zero, max_exp}, {1'b1, 10'd0});
        @(posedge clk);
        #1 reset = 1'b0; ready_out = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bt = mk(-5, -40, 3, -7, -20, 5'b00000, 28'd0, 4'b0001);
        directed("t6_after", bt, 10'd3, {6'd23, 6'd10, 6'd0, 6'd43, 6'd8}, 24'd0, 1'b0);

        // Random traffic with random backpressure.
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rnd_beat());
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 ready_out = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_out = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vx_tcu_drl_max_exp.md
Name: vx_tcu_drl_max_exp

Overview:
Stage directly downstream of the TCU DRL exponent/bias stage. Consumes the TCK product exponents plus the C-term exponent and finds the signed maximum over non-zero terms. Produces per-term right-shift amounts for significand alignment, plus saturated FP8/BF8 intra-pair shifts. Two-stage pipeline with valid/ready backpressure feeding the alignment shifters.

Parameters:
N, 2, dot-product lanes per 32-bit register pair
TCK, 2*N, product terms; term index TCK is the C term
W, 25, significand window width
EXP_W, 10, exponent width, two's complement
MAX_SHIFT, 2*W, shift saturation value
SHIFT_W, $clog2(MAX_SHIFT+1), shift field width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  input beat valid
ready_in  out  1  stage can accept input
raw_exp_y  in  (TCK+1)*EXP_W  signed term exponents
term_zero  in  TCK+1  term is zero or masked; excluded from max
exp_low_larger  in  TCK  FP8 pair: low sub-product larger
raw_exp_diff  in  TCK*7  FP8 pair exponent difference, signed 7-bit
valid_out  out  1  result valid
ready_out  in  1  downstream accepts result
max_exp  out  EXP_W  maximum exponent
shift_amt  out  (TCK+1)*SHIFT_W  max_exp - exp[i], saturated
sub_shift  out  TCK*SHIFT_W  |raw_exp_diff[i]|, saturated; smaller FP8 sub-product shift
low_larger_out  out  TCK  registered copy of exp_low_larger
all_zero  out  1  every term zero

Behaviour:
- Reset (async assert, sync deassert by the surrounding reset tree) clears both stage valids. valid_out=0, max_exp=0, shift_amt=0, sub_shift=0, low_larger_out=0, all_zero=1.
- Latency: 2 cycles, valid_in accept to valid_out, with no stall. Throughput: 1 beat/cycle.
- Handshake: a beat is accepted when valid_in & ready_in. Output is held stable while valid_out & ~ready_out. Each stage advances when empty or when its successor advances; bubbles collapse. ready_in = ~s1_valid | s2_adv. s2_adv = ~s2_valid | ready_out.
- Stage 1 registers: pairwise masked maxima of terms (0,1),(2,3),…; C term carried alone. Also registers raw exps, zero mask and FP8 fields. Zero terms are replaced by the most-negative EXP_W value.
- Stage 2 combinational:
  - reduce the pair maxima to max_exp (signed compare);
  - shift_amt[i] = min(max_exp - exp[i], MAX_SHIFT), computed at EXP_W+1 bits;
  - zero terms get MAX_SHIFT;
  - sub_shift[i] = min(|diff|, MAX_SHIFT), where diff = -64 is treated as 64.
- Stage 2 registers all outputs.
- All terms zero: max_exp=0, all_zero=1, every shift_amt=MAX_SHIFT.
- Ties: max is that value; tied terms get shift 0.
- Reset asserted mid-stream drops in-flight beats; no output after reset until new input arrives.

Optional Feature:
Macro TCU_DRL_MAX_EXP_STATS_EN.
- Defined: adds outputs sat_count[31:0] and zero_count[31:0]. These are wrapping counters.
  - sat_count increments once per accepted output beat (valid_out & ready_out) in which any non-zero term saturated.
  - zero_count increments once per output beat with all_zero.
  - Both counters are cleared by reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- VX_tcu_pkg gains SHIFT_W/MAX_SHIFT helper functions and a packed typedef tcu_exp_align_t {max_exp, shift_amt, sub_shift, low_larger, all_zero} for the stage-2 register.
- One sub-module: vx_tcu_drl_exp_max_tree, a combinational masked signed-max reduction (parameters count, width), instantiated for the stage-1 pair level and the stage-2 final level.

Test Plan:
1. Defaults; exps {C=120, 100, 110, 105, 90}, none zero, ready_out=1 -> after 2 cycles: max_exp=120, shift_amt {C=0, 20, 10, 15, 30}, all_zero=0.
2. Term 0 exp=200, term 3 exp=-30, others zero -> max_exp=200; shift_amt[3]=50 (230 clamped); zero terms shift 50.
3. All term_zero=1 -> max_exp=0, all_zero=1, all shifts 50; with stats enabled, zero_count increments by 1.
4. raw_exp_diff = {-5, 7, -64, 0} with low_larger flags -> sub_shift = {5, 7, 50, 0}; low_larger_out matches the input flags.
5. Continuous valid_in with ready_out=0 for 3 cycles -> output held stable; ready_in drops after 2 beats are buffered; no beat lost or duplicated after release; order preserved.
6. Assert reset with 2 beats in flight -> valid_out=0 immediately; outputs at reset values; the next input appears 2 cycles after acceptance.
